// File: rtl/pri_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with optional round-robin search.
// Valid/ready on both sides; one result per cycle while downstream accepts.
module pri_encoder_rr #(
  parameter int N          = 8,
  parameter int W          = $clog2(N),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [N-1:0] iData,
  input  logic         iValid,
  output logic         oReady,
  input  logic         iMode,
  output logic [W-1:0] oData,
  output logic         oNone,
  output logic         oValid,
  input  logic         iReady
);

  logic [N-1:0] req;
  logic [W-1:0] ptr;
  logic [W-1:0] gFix;
  logic [W-1:0] gRr;
  logic [W-1:0] grant;
  logic [W-1:0] ptrNext;
  logic         anyReq;
  logic         capture;

  assign req     = ACTIVE_LOW ? ~iData : iData;
  assign anyReq  = |req;
  assign oReady  = !oValid || iReady;
  assign capture = iValid && oReady;

  always_comb begin
    gFix = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) gFix = W'(i);
    end
  end

  // Walk from lowest to highest RR priority so the last hit (ptr) wins.
  always_comb begin
    int idx;
    gRr = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) - k + N) % N;
      if (req[idx]) gRr = W'(idx);
    end
  end

  assign grant   = iMode ? gRr : gFix;
  assign ptrNext = (grant == '0) ? W'(N - 1) : grant - W'(1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oNone  <= 1'b0;
      ptr    <= W'(N - 1);
    end else if (capture) begin
      oValid <= 1'b1;
      oData  <= anyReq ? grant : '0;
      oNone  <= !anyReq;
      if (iMode && anyReq) ptr <= ptrNext;
    end else if (iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pri_encoder_rr.sv
// Directed bench for pri_encoder_rr: N=8 active-low and N=5 active-high.
// Each task drives one scenario and checks against hand-computed values.
module tb_pri_encoder_rr;

  logic       clk;
  logic       rst;

  logic [7:0] d8;
  logic       v8, m8, r8;
  logic       rdy8, none8, ov8;
  logic [2:0] q8;

  logic [4:0] d5;
  logic       v5, m5, r5;
  logic       rdy5, none5, ov5;
  logic [2:0] q5;

  int checks = 0;
  int errors = 0;

  pri_encoder_rr #(.N(8), .ACTIVE_LOW(1'b1)) u8 (
    .iClk(clk), .iRst(rst), .iData(d8), .iValid(v8), .oReady(rdy8),
    .iMode(m8), .oData(q8), .oNone(none8), .oValid(ov8), .iReady(r8)
  );

  pri_encoder_rr #(.N(5), .ACTIVE_LOW(1'b0)) u5 (
    .iClk(clk), .iRst(rst), .iData(d5), .iValid(v5), .oReady(rdy5),
    .iMode(m5), .oData(q5), .oNone(none5), .oValid(ov5), .iReady(r5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v8 = 1'b1; d8 = 8'h00; m8 = 1'b0; r8 = 1'b1;
    step(); step();
    checks++;
    if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_oValid got %0b want 0", ov8); end
    checks++;
    if (q8 !== 3'd0) begin errors++; $display("FAIL reset_oData got %0d want 0", q8); end
    checks++;
    if (none8 !== 1'b0) begin errors++; $display("FAIL reset_oNone got %0b want 0", none8); end
    checks++;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_oReady got %0b want 1", rdy8); end
    checks++;
    if (u8.ptr !== 3'd7) begin errors++; $display("FAIL reset_ptr got %0d want 7", u8.ptr); end
    rst = 1'b0; m8 = 1'b1; d8 = 8'h00;
    step();
    checks++;
    if (ov8 !== 1'b1 || q8 !== 3'd7) begin
      errors++; $display("FAIL reset_first_rr got v=%0b d=%0d want v=1 d=7", ov8, q8);
    end
  endtask

  task automatic test_fixed_sweep();
    logic [7:0] vec [5];
    logic [2:0] expD [5];
    logic       expN [5];
    vec = '{8'hFF, 8'h7F, 8'h3F, 8'hFE, 8'hEF};
    expD = '{3'd0, 3'd7, 3'd7, 3'd0, 3'd4};
    expN = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    doReset();
    m8 = 1'b0; v8 = 1'b1; r8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d8 = vec[i];
      step();
      checks++;
      if (ov8 !== 1'b1 || q8 !== expD[i] || none8 !== expN[i]) begin
        errors++;
        $display("FAIL fixed_sweep[%0d] got v=%0b d=%0d n=%0b want v=1 d=%0d n=%0b",
                 i, ov8, q8, none8, expD[i], expN[i]);
      end
    end
    checks++;
    if (u8.ptr !== 3'd7) begin errors++; $display("FAIL fixed_ptr got %0d want 7", u8.ptr); end
  endtask

  task automatic test_rr_full();
    logic [2:0] expD [9];
    expD = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    doReset();
    m8 = 1'b1; v8 = 1'b1; r8 = 1'b1; d8 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (ov8 !== 1'b1 || q8 !== expD[i] || none8 !== 1'b0) begin
        errors++;
        $display("FAIL rr_full[%0d] got v=%0b d=%0d n=%0b want v=1 d=%0d n=0",
                 i, ov8, q8, none8, expD[i]);
      end
    end
  endtask

  // Follows test_rr_full: ptr starts at 6.
  task automatic test_rr_sparse();
    logic [2:0] expD [4];
    expD = '{3'd5, 3'd2, 3'd5, 3'd2};
    d8 = 8'b1101_1011;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (q8 !== expD[i]) begin
        errors++; $display("FAIL rr_sparse[%0d] got %0d want %0d", i, q8, expD[i]);
      end
    end
    m8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q8 !== 3'd5) begin
        errors++; $display("FAIL sparse_fixed[%0d] got %0d want 5", i, q8);
      end
    end
    checks++;
    if (u8.ptr !== 3'd1) begin errors++; $display("FAIL sparse_ptr got %0d want 1", u8.ptr); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] junk [3];
    junk = '{8'hFE, 8'hBF, 8'h00};
    doReset();
    m8 = 1'b1; v8 = 1'b1; r8 = 1'b1; d8 = 8'h00;
    step();
    r8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d8 = junk[i];
      #1;
      checks++;
      if (rdy8 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b want 0", i, rdy8); end
      step();
      checks++;
      if (ov8 !== 1'b1 || q8 !== 3'd7 || u8.ptr !== 3'd6) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%0b d=%0d ptr=%0d want v=1 d=7 ptr=6",
                 i, ov8, q8, u8.ptr);
      end
    end
    r8 = 1'b1; d8 = 8'hFB;
    #1;
    checks++;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", rdy8); end
    step();
    checks++;
    if (ov8 !== 1'b1 || q8 !== 3'd2 || u8.ptr !== 3'd1) begin
      errors++;
      $display("FAIL bp_release got v=%0b d=%0d ptr=%0d want v=1 d=2 ptr=1", ov8, q8, u8.ptr);
    end
    r8 = 1'b1; v8 = 1'b0;
    step();
    checks++;
    if (ov8 !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", ov8); end
  endtask

  task automatic test_reset_mid();
    doReset();
    m8 = 1'b1; v8 = 1'b1; r8 = 1'b1; d8 = 8'h00;
    for (int i = 0; i < 4; i++) step();
    r8 = 1'b0; d8 = 8'hF0;
    step();
    checks++;
    if (u8.ptr !== 3'd3 || q8 !== 3'd4 || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall got ptr=%0d d=%0d v=%0b want ptr=3 d=4 v=1", u8.ptr, q8, ov8);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%0b rdy=%0b want v=0 rdy=1", ov8, rdy8);
    end
    r8 = 1'b1; d8 = 8'h00;
    step();
    checks++;
    if (q8 !== 3'd7 || ov8 !== 1'b1) begin
      errors++; $display("FAIL mid_regrant got d=%0d v=%0b want d=7 v=1", q8, ov8);
    end
  endtask

  task automatic test_npot();
    logic [2:0] expD [6];
    expD = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    v8 = 1'b0;
    doReset();
    checks++;
    if (u5.ptr !== 3'd4) begin errors++; $display("FAIL npot_reset_ptr got %0d want 4", u5.ptr); end
    m5 = 1'b1; v5 = 1'b1; r5 = 1'b1; d5 = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ov5 !== 1'b1 || q5 !== expD[i] || u5.ptr > 3'd4) begin
        errors++;
        $display("FAIL npot[%0d] got v=%0b d=%0d ptr=%0d want v=1 d=%0d ptr<5",
                 i, ov5, q5, u5.ptr, expD[i]);
      end
    end
    d5 = 5'b00000;
    step();
    checks++;
    if (none5 !== 1'b1 || q5 !== 3'd0 || u5.ptr !== 3'd3) begin
      errors++;
      $display("FAIL npot_empty got n=%0b d=%0d ptr=%0d want n=1 d=0 ptr=3", none5, q5, u5.ptr);
    end
  endtask

  initial begin
    rst = 1'b1;
    d8 = '0; v8 = 1'b0; m8 = 1'b0; r8 = 1'b1;
    d5 = '0; v5 = 1'b0; m5 = 1'b0; r5 = 1'b1;
    test_reset();
    test_fixed_sweep();
    test_rr_full();
    test_rr_sparse();
    test_back_pressure();
    test_reset_mid();
    test_npot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
